// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
// Request/response handshake (start / busy / done) with operands latched on
// accept, divide-by-zero detection, and an optional two's-complement mode
// compiled in only when the macro DIV_SIGNED_EN is defined.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_TOP  = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  // The dividend register doubles as the quotient register: each step shifts
  // the next dividend bit out of the MSB and the new quotient bit into the LSB.
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  // Partial remainder. Its extra top bit is always zero after a step (P < divisor),
  // so only the low WIDTH bits are stored; the compare itself is WIDTH+1 bits wide.
  logic [WIDTH-1:0] p_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;

  logic [WIDTH:0]   pn_s;
  logic [WIDTH:0]   diff_s;
  logic             ge_s;
  logic [WIDTH-1:0] p_nxt_s;
  logic [WIDTH-1:0] dvd_nxt_s;
  logic [WIDTH-1:0] dvd_mag_s;
  logic [WIDTH-1:0] dvs_mag_s;
  logic [WIDTH-1:0] quot_fin_s;
  logic [WIDTH-1:0] rem_fin_s;

`ifdef DIV_SIGNED_EN
  logic neg_quot_q;
  logic neg_rem_q;
  logic dvd_neg_s;
  logic dvs_neg_s;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return (~x) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Operand magnitudes and result sign fix-up for two's-complement requests
  always_comb begin
    dvd_neg_s = signed_mode & dividend[WIDTH-1];
    dvs_neg_s = signed_mode & divisor[WIDTH-1];
    if (dvd_neg_s) begin
      dvd_mag_s = negate(dividend);
    end else begin
      dvd_mag_s = dividend;
    end
    if (dvs_neg_s) begin
      dvs_mag_s = negate(divisor);
    end else begin
      dvs_mag_s = divisor;
    end
    if (neg_quot_q) begin
      quot_fin_s = negate(dvd_nxt_s);
    end else begin
      quot_fin_s = dvd_nxt_s;
    end
    if (neg_rem_q) begin
      rem_fin_s = negate(p_nxt_s);
    end else begin
      rem_fin_s = p_nxt_s;
    end
  end
`else
  // Unsigned-only build: the mode input has no effect on the datapath.
  logic unused_signed_mode_s;
  assign unused_signed_mode_s = signed_mode;

  // Operands and results pass straight through in the unsigned-only build
  always_comb begin
    dvd_mag_s  = dividend;
    dvs_mag_s  = divisor;
    quot_fin_s = dvd_nxt_s;
    rem_fin_s  = p_nxt_s;
  end
`endif

  // One restoring step: the borrow of the (WIDTH+1)-bit subtract is the compare
  always_comb begin
    pn_s   = {p_q, dvd_q[WIDTH-1]};
    diff_s = pn_s - {1'b0, dvs_q};
    if (diff_s[WIDTH] == 1'b0) begin
      ge_s    = 1'b1;
      p_nxt_s = diff_s[WIDTH-1:0];
    end else begin
      ge_s    = 1'b0;
      p_nxt_s = pn_s[WIDTH-1:0];
    end
    dvd_nxt_s = {dvd_q[WIDTH-2:0], ge_s};
  end

  // Control FSM, iteration datapath and registered result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      dvd_q   <= ZERO_W;
      dvs_q   <= ZERO_W;
      p_q     <= ZERO_W;
      cnt_q   <= CNT_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= ZERO_W;
      rem_q   <= ZERO_W;
      dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_RUN: begin
          p_q   <= p_nxt_s;
          dvd_q <= dvd_nxt_s;
          if (cnt_q == CNT_ZERO) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quot_q  <= quot_fin_s;
            rem_q   <= rem_fin_s;
            dbz_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        S_IDLE, S_DONE: begin
          if (start) begin
            dvd_q <= dvd_mag_s;
            dvs_q <= dvs_mag_s;
            p_q   <= ZERO_W;
            cnt_q <= CNT_TOP;
`ifdef DIV_SIGNED_EN
            neg_quot_q <= dvd_neg_s ^ dvs_neg_s;
            neg_rem_q  <= dvd_neg_s;
`endif
            if (divisor == ZERO_W) begin
              // Divide by zero completes immediately without iterating.
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              quot_q  <= ONES_W;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8): directed handshake, latency,
// divide-by-zero, ignored-start and reset-abort cases plus a randomized sweep.
module tb_seq_divider;

  localparam int W = 8;
`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         signed_mode;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .signed_mode (signed_mode),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    exp_t e;
    e.q = q;
    e.r = r;
    e.z = z;
    return e;
  endfunction

  // Reference model: plain integer division, truncating toward zero when signed.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    int sa;
    int sbv;
    if (b == 8'd0) return mk(8'hFF, a, 1'b1);
    if (sm && SIGNED_EN) begin
      sa  = int'($signed(a));
      sbv = int'($signed(b));
      return mk(8'(sa / sbv), 8'(sa % sbv), 1'b0);
    end
    return mk(a / b, a % b, 1'b0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns at the negedge after the accepting edge.
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    @(negedge clk);
    dividend    = a;
    divisor     = b;
    signed_mode = sm;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge after the accepting edge; waits for done and scores it.
  task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
    int   n  = 0;
    int   bc = 0;
    exp_t e;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_busy_cycles"}, bc, exp_busy);
    if (sb.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, sb.size(), 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_quotient"}, quotient, e.q);
      chk({tag, "_remainder"}, remainder, e.r);
      chk({tag, "_div_by_zero"}, div_by_zero, e.z);
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sm, input exp_t e, input int lat, input int bsy);
    sb.push_back(e);
    drive(a, b, sm);
    wait_done(tag, lat, bsy);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int   seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rs;

    reset       = 1'b1;
    start       = 1'b0;
    dividend    = 8'd0;
    divisor     = 8'd0;
    signed_mode = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_div_by_zero", div_by_zero, 0);
    reset = 1'b0;

    // Basic operation and latency
    run_op("t1_200_7", 8'd200, 8'd7, 1'b0, mk(8'd28, 8'd4, 1'b0), 8, 8);

    // Back-to-back with start held through DONE; operands change during RUN
    sb.push_back(mk(8'd1, 8'd55, 1'b0));
    @(negedge clk);
    dividend = 8'd255;
    divisor  = 8'd200;
    start    = 1'b1;
    @(negedge clk);
    divisor = 8'd1;
    sb.push_back(mk(8'd255, 8'd0, 1'b0));
    wait_done("t2a_255_200", 8, 8);
    @(negedge clk);
    start = 1'b0;
    chk("t2_no_idle_gap_busy", busy, 1);
    chk("t2_no_idle_gap_done", done, 0);
    wait_done("t2b_255_1", 8, 8);
    @(negedge clk);
    chk("t2b_done_pulse", done, 0);

    // Divide by zero, then a normal op clears the flag
    run_op("t3_37_0", 8'd37, 8'd0, 1'b0, mk(8'hFF, 8'd37, 1'b1), 0, 0);
    run_op("t3_9_3", 8'd9, 8'd3, 1'b0, mk(8'd3, 8'd0, 1'b0), 8, 8);

    // Start during RUN is ignored
    sb.push_back(mk(8'd11, 8'd1, 1'b0));
    drive(8'd100, 8'd9, 1'b0);
    repeat (2) @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t4_ignored_start", 5, 5);
    @(negedge clk);
    chk("t4_done_pulse", done, 0);
    chk("t4_not_restarted", busy, 0);

    // Reset mid-operation abandons it
    drive(8'd100, 8'd9, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_quotient", quotient, 0);
    chk("t5_rst_remainder", remainder, 0);
    chk("t5_rst_div_by_zero", div_by_zero, 0);
    @(negedge clk);
    reset = 1'b0;
    seen  = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1;
    end
    chk("t5_no_activity_after_reset", seen, 0);
    run_op("t5_fresh_100_9", 8'd100, 8'd9, 1'b0, mk(8'd11, 8'd1, 1'b0), 8, 8);

    // Divisor with MSB set
    run_op("msb_divisor", 8'd200, 8'd129, 1'b0, mk(8'd1, 8'd71, 1'b0), 8, 8);

    // Signed-mode requests (unsigned results when the feature is compiled out)
`ifdef DIV_SIGNED_EN
    run_op("t6_m7_2", 8'hF9, 8'd2, 1'b1, mk(8'hFD, 8'hFF, 1'b0), 8, 8);
    run_op("t6_7_m2", 8'd7, 8'hFE, 1'b1, mk(8'hFD, 8'h01, 1'b0), 8, 8);
    run_op("t6_m128_m1", 8'h80, 8'hFF, 1'b1, mk(8'h80, 8'h00, 1'b0), 8, 8);
    run_op("t6_m7_0", 8'hF9, 8'd0, 1'b1, mk(8'hFF, 8'hF9, 1'b1), 0, 0);
`else
    run_op("t6_m7_2", 8'hF9, 8'd2, 1'b1, mk(8'd124, 8'd1, 1'b0), 8, 8);
    run_op("t6_7_m2", 8'd7, 8'hFE, 1'b1, mk(8'd0, 8'd7, 1'b0), 8, 8);
    run_op("t6_m128_m1", 8'h80, 8'hFF, 1'b1, mk(8'd0, 8'd128, 1'b0), 8, 8);
`endif
    run_op("t6_unsigned_249_2", 8'hF9, 8'd2, 1'b0, mk(8'd124, 8'd1, 1'b0), 8, 8);

    // Randomized sweep against the reference model
    for (int k = 0; k < 16; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (k % 5 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      rs = 1'($urandom_range(0, 1));
      run_op("rand", ra, rb, rs, model(ra, rb, rs), (rb == 8'd0) ? 0 : 8, (rb == 8'd0) ? 0 : 8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Parametrised multi-cycle restoring divider that produces one quotient bit per clock. It replaces the fixed 8-bit unsigned divider. The block adds a start/busy/done handshake, operand latching, a WIDTH parameter, divide-by-zero detection and an optional signed mode. It sits as a shared arithmetic unit behind a simple request/response interface in datapath blocks.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  reset, asynchronous, active-high.
start  input  1  request. Sampled only when the block can accept (state IDLE or DONE).
dividend  input  WIDTH  numerator. Latched on an accepted start.
divisor  input  WIDTH  denominator. Latched on an accepted start.
signed_mode  input  1  treat operands as two's complement. Latched on an accepted start. Ignored unless DIV_SIGNED_EN is defined.
busy  output  1  high while state is RUN.
done  output  1  one-cycle pulse: results valid.
quotient  output  WIDTH  registered quotient.
remainder  output  WIDTH  registered remainder.
div_by_zero  output  1  registered flag for the last completed operation.

Behaviour:
- Reset values: state IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. Internal counter and partial registers are cleared.
- Reset asserted mid-operation: the operation is abandoned immediately. No done pulse follows.
- States:
  - IDLE -> RUN on start with divisor!=0.
  - IDLE -> DONE on start with divisor==0.
  - RUN -> DONE after the edge that processes bit 0.
  - DONE -> IDLE when start=0.
  - DONE -> RUN/DONE when start=1. Back-to-back requests are accepted with no idle gap.
- start while in RUN is ignored. Latched operands are unaffected.
- Accepting edge:
  - Latch the operand magnitudes.
  - Set bit counter = WIDTH-1.
  - Clear the partial remainder P (WIDTH+1 bits) and the partial quotient Q.
- Each RUN edge, for bit i = counter:
  - Pn = {P[WIDTH-1:0], dividend_latched[i]}.
  - If Pn >= {1'b0, divisor}: P <= Pn - divisor and shift 1 into Q. Otherwise P <= Pn and shift 0 into Q.
  - Decrement counter.
  - The WIDTH+1 bit compare is mandatory so that divisors with MSB=1 are correct.
- Latency (normal case):
  - done is high during the cycle following the WIDTH-th edge after the accepting edge.
  - busy is high for exactly WIDTH cycles.
- Latency (divide by zero):
  - done is high the cycle right after the accepting edge.
  - quotient = all ones, remainder = dividend, div_by_zero=1.
- quotient, remainder and div_by_zero update only on the edge entering DONE. They hold until the next completion, including through IDLE.
- div_by_zero is 0 for every non-zero divisor result.
- Unsigned identity (divisor!=0): dividend = quotient*divisor + remainder, with remainder < divisor.

Optional Feature:
Macro DIV_SIGNED_EN.
- Defined, signed_mode=1 at accept:
  - Operands are converted to magnitudes at accept.
  - The core runs unsigned.
  - At DONE, the quotient is negated if the operand signs differ, and the remainder is negated if the dividend is negative. Division truncates toward zero.
  - Most-negative / -1 gives quotient = most-negative (wrap), remainder = 0. No flag is raised.
  - Divide by zero gives quotient = all ones (-1), remainder = dividend, div_by_zero=1.
- Not defined: signed_mode is unconnected internally. All operations are unsigned. No sign logic is synthesised.

Test Plan:
1. WIDTH=8, start with 200/7 -> done exactly 8 edges after accept; quotient=28, remainder=4, div_by_zero=0; busy high for 8 cycles.
2. 255/200 then 255/1, issued back-to-back with start held through DONE -> 1 r 55, then 255 r 0; no IDLE cycle between the two operations.
3. 37/0 -> done one cycle after accept; quotient=0xFF, remainder=37, div_by_zero=1. A following 9/3 -> quotient=3, remainder=0, flag cleared.
4. Start 100/9; pulse start with 50/5 at cycle 3 of RUN -> the second start is ignored; result is 11 r 1.
5. Start 100/9; assert reset at cycle 4 of RUN -> all outputs 0, state IDLE, no done pulse; a fresh 100/9 then gives 11 r 1.
6. DIV_SIGNED_EN, signed_mode=1:
   - -7/2 -> 0xFD r 0xFF.
   - 7/-2 -> 0xFD r 0x01.
   - -128/-1 -> 0x80 r 0x00.
   - The same -7/2 operands with signed_mode=0 -> 249/2 = 124 r 1.
